// File: rtl/note_seq_pkg.sv
// Shared types and the note encoder for the note sequencer.
// Widths are bounded by MAX_S/MAX_F; callers zero-extend.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_e;

  localparam int MAX_S = 16;
  localparam int MAX_F = 15;
  localparam int MAX_W = MAX_S * (MAX_F + 1);

  function automatic int note_w(input int ns, input int nf);
    return ns * (nf + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Highest pressed bar wins; the string group shifts to that row.
  function automatic logic [MAX_W-1:0] encode_note(
    input logic [MAX_S-1:0] s,
    input logic [MAX_F-1:0] f,
    input int               ns
  );
    int eff;
    eff = 0;
    for (int k = 0; k < MAX_F; k++)
      if (f[k]) eff = k + 1;
    return {{(MAX_W-MAX_S){1'b0}}, s} << (eff * ns);
  endfunction

endpackage

// File: rtl/note_seq_if.sv
// Control/status bundle between the sequencer and its host.
// master drives commands and inputs, slave is the sequencer.
interface note_seq_if #(
  parameter int N_STRINGS = 6,
  parameter int N_FRETS   = 4,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = 27
);
  localparam int NOTE_W = N_STRINGS * (N_FRETS + 1);
  localparam int AW     = $clog2(DEPTH);

  logic                 start_rec;
  logic                 start_play;
  logic                 stop;
  logic                 loop_en;
  logic [CNT_W-1:0]     beat_period;
  logic [N_STRINGS-1:0] strings;
  logic [N_FRETS-1:0]   frets;
  logic [NOTE_W-1:0]    note_out;
  logic                 note_valid;
  logic                 beat_tick;
  logic                 busy;
  logic [1:0]           state;
  logic [AW:0]          rec_len;
  logic                 full;
  logic                 done;

  modport master (
    output start_rec, start_play, stop, loop_en,
    output beat_period, strings, frets,
    input  note_out, note_valid, beat_tick, busy,
    input  state, rec_len, full, done
  );

  modport slave (
    input  start_rec, start_play, stop, loop_en,
    input  beat_period, strings, frets,
    output note_out, note_valid, beat_tick, busy,
    output state, rec_len, full, done
  );
endinterface

// File: rtl/beat_timer.sv
// Beat counter: ticks on the last cycle of each period.
// Held cleared while restart is high; period latched at wrap.
module beat_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] last_d;

  assign last_d = (period == '0) ? '0 : period - CNT_W'(1);
  assign tick   = !restart && (cnt == last);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      last <= '0;
    end else if (restart || tick) begin
      cnt  <= '0;
      last <= last_d;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/note_store.sv
// Note word storage: sync write, registered read.
// Kept as its own block so a BRAM macro can drop in.
module note_store #(
  parameter int W     = 30,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end
endmodule

// File: rtl/note_sequencer.sv
// Beat-paced guitar note recorder/player with loop,
// stop and full handling.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int N_STRINGS = 6,
  parameter int N_FRETS   = 4,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = 27
) (
  input logic       clk,
  input logic       resetn,
  note_seq_if.slave bus
);
  localparam int NOTE_W = note_w(N_STRINGS, N_FRETS);
  localparam int AW     = addr_w(DEPTH);

  state_e state_q, state_d;

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          rec_len;
  logic [N_STRINGS-1:0] s_acc, s_cap;
  logic [N_FRETS-1:0]   f_acc, f_cap;
  logic [NOTE_W-1:0]    wr_word;

  logic tick, busy;
  logic wr_en, rd_en;
  logic clr_rec, clr_rd;
  logic done_d, done_q;
  logic note_valid_q;
  logic wr_last, rd_last;

  assign busy = (state_q != IDLE);

  // Timer idles in IDLE so every entry starts a full beat.
  beat_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .restart (!busy),
    .period  (bus.beat_period),
    .tick    (tick)
  );

  assign s_cap   = s_acc | bus.strings;
  assign f_cap   = f_acc | bus.frets;
  assign wr_word = NOTE_W'(encode_note(
                     MAX_S'(s_cap), MAX_F'(f_cap), N_STRINGS));

  assign wr_last = (wr_ptr == AW'(DEPTH - 1));
  assign rd_last = (({1'b0, rd_ptr} + (AW+1)'(1)) == rec_len);

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_rec = 1'b0;
    clr_rd  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.stop) begin
          if (bus.start_rec) begin
            clr_rec = 1'b1;
            state_d = REC;
          end else if (bus.start_play) begin
            if (rec_len != '0) begin
              clr_rd  = 1'b1;
              state_d = PLAY;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      REC: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tick) begin
          wr_en = 1'b1;
          if (wr_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tick) begin
          rd_en = 1'b1;
          if (rd_last && !bus.loop_en) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rec_len      <= '0;
      s_acc        <= '0;
      f_acc        <= '0;
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      note_valid_q <= rd_en;
      done_q       <= done_d;
      if (clr_rec) begin
        wr_ptr  <= '0;
        rec_len <= '0;
      end else if (wr_en) begin
        wr_ptr  <= wr_ptr + AW'(1);
        rec_len <= rec_len + (AW+1)'(1);
      end
      if (clr_rd)
        rd_ptr <= '0;
      else if (rd_en)
        rd_ptr <= rd_last ? '0 : rd_ptr + AW'(1);
      if (state_q == REC && !tick && !bus.stop) begin
        s_acc <= s_cap;
        f_acc <= f_cap;
      end else begin
        s_acc <= '0;
        f_acc <= '0;
      end
    end
  end

  note_store #(.W(NOTE_W), .DEPTH(DEPTH)) u_store (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_en),
    .waddr  (wr_ptr),
    .wdata  (wr_word),
    .re     (rd_en),
    .raddr  (rd_ptr),
    .rdata  (bus.note_out)
  );

  assign bus.note_valid = note_valid_q;
  assign bus.done       = done_q;
  assign bus.beat_tick  = tick;
  assign bus.busy       = busy;
  assign bus.state      = state_q;
  assign bus.rec_len    = rec_len;
  assign bus.full       = (rec_len == (AW+1)'(DEPTH));
endmodule

// File: tb/tb_note_sequencer.sv
// Randomized scoreboard bench for note_sequencer.
// Reference keeps recorded notes in a queue.
module tb_note_sequencer;
  localparam int NS    = 6;
  localparam int NF    = 4;
  localparam int DEPTH = 4;
  localparam int NW    = NS * (NF + 1);

  typedef struct {
    logic [NW-1:0] note;
    int            cyc;
    bit            done;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;
  int   P;
  int   exp_done_solo;

  exp_t          sb[$];
  exp_t          e;
  logic [NW-1:0] rec_q[$];
  logic [NW-1:0] last_note;
  logic [NS-1:0] dir_s [3];
  logic [NF-1:0] dir_f [3];

  note_seq_if #(
    .N_STRINGS(NS), .N_FRETS(NF), .DEPTH(DEPTH), .CNT_W(8)
  ) bus ();

  note_sequencer #(
    .N_STRINGS(NS), .N_FRETS(NF), .DEPTH(DEPTH), .CNT_W(8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", n, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bp(input int v);
    bus.beat_period = 8'(v);
    P = (v == 0) ? 1 : v;
  endtask

  function automatic logic [NW-1:0] ref_encode(
    input logic [NS-1:0] s, input logic [NF-1:0] f);
    logic [NW-1:0] w;
    int fr;
    fr = 0;
    for (int k = NF; k >= 1; k--)
      if (f[k-1] && fr == 0) fr = k;
    w = '0;
    for (int i = 0; i < NS; i++) w[fr*NS + i] = s[i];
    return w;
  endfunction

  task automatic record(input int nbeats, input int stop_j,
                        input bit both, input bit directed);
    logic [NS-1:0] acc_s, s;
    logic [NF-1:0] acc_f, f;
    bus.start_rec  = 1'b1;
    bus.start_play = both;
    step();
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    chk("rec_state", bus.state, 1);
    chk("rec_busy", bus.busy, 1);
    rec_q.delete();
    acc_s = '0;
    acc_f = '0;
    for (int b = 0; b <= nbeats; b++) begin
      for (int j = 0; j < P; j++) begin
        if (directed && b < 3) begin
          s = dir_s[b];
          f = dir_f[b];
        end else begin
          s = NS'($urandom);
          f = ($urandom_range(0, 2) == 0) ? NF'($urandom) : '0;
        end
        bus.strings = s;
        bus.frets   = f;
        if (b == nbeats && j == stop_j) begin
          bus.stop = 1'b1;
          step();
          bus.stop = 1'b0;
          chk("rec_stop_state", bus.state, 0);
          chk("rec_len", bus.rec_len, rec_q.size());
          chk("rec_full", bus.full, rec_q.size() == DEPTH);
          return;
        end
        chk("rec_tick", bus.beat_tick, j == P - 1);
        acc_s |= s;
        acc_f |= f;
        if (j == P - 1) begin
          rec_q.push_back(ref_encode(acc_s, acc_f));
          acc_s = '0;
          acc_f = '0;
          if (rec_q.size() == DEPTH) begin
            exp_done_solo++;
            step();
            chk("full_state", bus.state, 0);
            chk("full_flag", bus.full, 1);
            chk("full_len", bus.rec_len, DEPTH);
            return;
          end
        end
        step();
      end
    end
  endtask

  task automatic play(input bit loop, input int stop_after,
                      input int stop_j, input bit use_reset);
    int  idx, notes, t0;
    bit  fin, aborted, last;
    idx     = 0;
    notes   = 0;
    fin     = 0;
    aborted = 0;
    bus.loop_en    = loop;
    bus.start_play = 1'b1;
    if (rec_q.size() == 0) exp_done_solo++;
    step();
    bus.start_play = 1'b0;
    if (rec_q.size() == 0) begin
      chk("empty_state", bus.state, 0);
      repeat (P + 3) step();
      chk("empty_done_seen", exp_done_solo, 0);
      return;
    end
    chk("play_state", bus.state, 2);
    t0 = cyc;
    while (!fin) begin
      for (int j = 0; j < P && !fin; j++) begin
        if (cyc - t0 > 500) begin
          chk("play_budget", cyc - t0, 500);
          fin = 1;
          aborted = 1;
        end else if (notes == stop_after && j == stop_j) begin
          if (use_reset) resetn = 1'b0;
          else           bus.stop = 1'b1;
          step();
          resetn   = 1'b1;
          bus.stop = 1'b0;
          fin      = 1;
          aborted  = 1;
          chk("abort_state", bus.state, 0);
          chk("abort_done", bus.done, 0);
          chk("abort_valid", bus.note_valid, 0);
          if (use_reset) begin
            rec_q.delete();
            last_note = '0;
            chk("rst_len", bus.rec_len, 0);
            chk("rst_note", bus.note_out, 0);
            chk("rst_tick", bus.beat_tick, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_full", bus.full, 0);
          end else begin
            chk("stop_hold", bus.note_out, last_note);
          end
        end else begin
          chk("play_tick", bus.beat_tick, j == P - 1);
          if (j == P - 1) begin
            last = (idx == rec_q.size() - 1);
            sb.push_back('{note: rec_q[idx], cyc: cyc + 1,
                           done: last && !loop});
            last_note = rec_q[idx];
            notes++;
            if (last) begin
              if (loop) idx = 0;
              else      fin = 1;
            end else begin
              idx++;
            end
          end
          step();
        end
      end
    end
    if (!aborted) begin
      chk("play_end_state", bus.state, 0);
      chk("play_end_busy", bus.busy, 0);
    end
  endtask

  always @(negedge clk) begin
    if (bus.note_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_note: got %0h required none",
                 bus.note_out);
      end else begin
        e = sb.pop_front();
        chk("note_word", bus.note_out, e.note);
        chk("note_cycle", cyc, e.cyc);
        chk("note_done", bus.done, e.done);
      end
    end else if (bus.done) begin
      checks++;
      if (exp_done_solo == 0) begin
        errors++;
        $display("FAIL unexpected_done: got 1 required 0");
      end else begin
        exp_done_solo--;
      end
    end
  end

  initial begin
    int bp, nb, sj, lp;
    clk = 0; cyc = 0; checks = 0; errors = 0;
    exp_done_solo = 0;
    last_note = '0;
    resetn = 1'b0;
    bus.start_rec = 0; bus.start_play = 0; bus.stop = 0;
    bus.loop_en = 0; bus.strings = '0; bus.frets = '0;
    set_bp(4);
    dir_s[0] = 6'b000001; dir_f[0] = 4'b0100;
    dir_s[1] = 6'b100001; dir_f[1] = 4'b0000;
    dir_s[2] = 6'b010010; dir_f[2] = 4'b1010;
    repeat (3) step();
    chk("reset_state", bus.state, 0);
    chk("reset_len", bus.rec_len, 0);
    chk("reset_note", bus.note_out, 0);
    chk("reset_valid", bus.note_valid, 0);
    chk("reset_tick", bus.beat_tick, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_full", bus.full, 0);
    resetn = 1'b1;
    step();

    record(3, 1, 0, 1);
    play(0, 99, 0, 0);

    record(5, 0, 0, 0);
    repeat (6) step();
    chk("no_write_after_full", bus.rec_len, DEPTH);
    play(0, 99, 0, 0);

    record(2, P - 1, 0, 0);
    play(1, 5, 2, 0);
    chk("loop_hold_a", bus.note_out, rec_q[0]);

    record(0, 0, 1, 0);
    play(0, 99, 0, 0);

    set_bp(0);
    record(3, 0, 0, 0);
    play(0, 99, 0, 0);

    repeat (12) begin
      bp = $urandom_range(0, 5);
      set_bp(bp);
      nb = $urandom_range(0, 5);
      sj = $urandom_range(0, P - 1);
      record(nb, sj, 1'($urandom), 0);
      lp = $urandom_range(0, 1);
      sj = $urandom_range(0, P - 1);
      play(lp[0], $urandom_range(0, 6), sj, 0);
      repeat (2) step();
    end

    set_bp(3);
    record(2, 0, 0, 0);
    play(1, 3, 1, 1);

    repeat (5) step();
    chk("sb_drained", sb.size(), 0);
    chk("done_drained", exp_done_solo, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Parametrised guitar-note recorder/player for the fret-board front end.
- A programmable beat timer drives it. Each beat it OR-accumulates the string and fret-bar inputs and encodes them into a one-hot string×fret note word.
- In record mode each beat's word is written into internal storage. In play mode the stored words are replayed once per beat to the audio stage, optionally looping.
- Replaces the fixed 6-string/4-bar/64-entry recorder with a generic block that adds looping, stop/full handling and a recorded-length register.

Parameters:
- N_STRINGS, 6, number of string inputs
- N_FRETS, 4, number of fret-bar inputs (open position is implicit)
- DEPTH, 64, number of note words stored (power of 2, at least 2)
- CNT_W, 27, width of the beat-period counter
- Derived: NOTE_W = N_STRINGS*(N_FRETS+1); AW = clog2(DEPTH)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start_rec  in  1  one-cycle pulse: begin recording
- start_play  in  1  one-cycle pulse: begin playback
- stop  in  1  one-cycle pulse: abort the current operation
- loop_en  in  1  playback wraps to entry 0 instead of finishing
- beat_period  in  CNT_W  clock cycles per beat; 0 is treated as 1
- strings  in  N_STRINGS  string-struck inputs, active-high
- frets  in  N_FRETS  fret-bar pressed inputs, active-high; bit k is fret k+1
- note_out  out  NOTE_W  current played note word
- note_valid  out  1  one-cycle pulse when note_out updates
- beat_tick  out  1  one-cycle pulse at each beat boundary
- busy  out  1  high in REC or PLAY
- state  out  2  IDLE=0, REC=1, PLAY=2
- rec_len  out  AW+1  number of valid stored words
- full  out  1  rec_len == DEPTH
- done  out  1  one-cycle pulse when record or playback finishes

Behaviour:
- Reset (resetn low at a clk edge):
  - state IDLE; all pointers, counters and accumulators 0.
  - rec_len 0; note_out 0.
  - note_valid, beat_tick, done, busy, full all 0.
  - Storage contents undefined.
- Beat timer:
  - cnt counts 0 .. P-1, where P = max(beat_period, 1).
  - beat_tick is asserted combinationally while cnt == P-1; cnt then wraps to 0.
  - cnt is forced to 0 on every state entry, so the first beat is always full length.
  - beat_period changes take effect at the next wrap.
- Accumulation (REC only):
  - s_acc |= strings and f_acc |= frets every cycle.
  - On a tick cycle the captured value is acc | current input, and both accumulators clear to 0 on the next edge.
- Encoding:
  - eff_fret = 0 if no fret bit is set; otherwise (index of the highest set fret bit) + 1.
  - note bit [eff_fret*N_STRINGS + s] = captured string s.
  - All other bits 0.
- IDLE:
  - Command priority: stop > start_rec > start_play.
  - start_rec: wr_ptr <- 0, rec_len <- 0, go to REC.
  - start_play when rec_len > 0: rd_ptr <- 0, go to PLAY.
  - start_play when rec_len == 0: done pulses next cycle; stay in IDLE.
- REC:
  - On tick, the encoded word is written at wr_ptr, then wr_ptr and rec_len increment.
  - When the write fills entry DEPTH-1: full=1, done pulses, go to IDLE.
  - stop: go to IDLE with rec_len unchanged; the partial beat is discarded; no done pulse.
  - start_* pulses are ignored.
- PLAY:
  - On tick, note_out <- mem[rd_ptr] and note_valid = 1 on the following cycle (1-cycle latency from tick).
  - If rd_ptr == rec_len-1 and loop_en = 1: rd_ptr <- 0.
  - If rd_ptr == rec_len-1 and loop_en = 0: done pulses with note_valid; go to IDLE.
  - Otherwise rd_ptr increments.
  - loop_en is sampled at the last entry.
  - stop: go to IDLE; note_out holds; no done pulse.
  - start_* pulses are ignored.
- note_out holds its value between updates and in IDLE.
- A stop coincident with a tick wins: no write, no read.
- A resetn assertion mid-operation aborts immediately to the reset state.

Decomposition:
- Shared package note_seq_pkg:
  - state enum (IDLE/REC/PLAY)
  - function encode_note(strings, frets) returning NOTE_W bits
  - NOTE_W and AW helper constants
- Sub-module beat_timer: CNT_W counter with period, restart and tick ports.
- Storage is an inferred register array with synchronous write and registered read; it is wrapped for later BRAM replacement.

Test Plan:
- Encoding, beat_period=4, REC. String 0 struck with fret 3 (frets=4'b0100) → word bit 18 set. No fret with strings=6'b100001 → bits 0 and 5 set. frets=4'b1010 → fret 4 wins (bits 24..29 region).
- Record 3 beats then stop, then start_play with loop_en=0 → three note_valid pulses spaced 4 cycles apart, each 1 cycle after beat_tick. Words match recorded values; done coincides with the third note; state returns to 0.
- Record until full with DEPTH=4 → after the 4th tick full=1, rec_len=4, done pulse, state IDLE; later ticks cause no writes.
- Loop play with rec_len=2, loop_en=1 → note sequence A,B,A,B,A. stop after 5 notes → IDLE, note_out holds A, no done pulse.
- start_play with rec_len=0 → done pulses, state stays 0, note_valid never asserts. start_rec and start_play in the same cycle → REC.
- resetn low mid-PLAY → next cycle state=0, rec_len=0, note_out=0, all pulses 0. beat_period=0 → beat_tick every cycle.
